// File: rtl/node_layer_sequencer.sv
// node_layer_sequencer: computes a whole fully-connected layer on one shared
// float multiply/add pair, one neuron at a time, with ReLU on each result.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start / busy / done layer request, in-progress flag, completion pulse
//   act_addr/act_data   activation ROM/RAM port (1-cycle read latency)
//   w_addr/w_data       weight port, address j*N_IN+i
//   b_addr/b_data       bias port, address j
//   mul_x/mul_y/mul_z   operands to / product from the external multiplier
//   add_a/add_b/add_out operands to / sum from the external adder
//   out_we/out_addr/out_data  output buffer write port
module node_layer_sequencer #(
    parameter int N_IN  = 15,
    parameter int N_OUT = 32,
    parameter int AW_A  = 4,
    parameter int AW_W  = 9,
    parameter int AW_O  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [AW_A-1:0] act_addr,
    input  logic [31:0]     act_data,
    output logic [AW_W-1:0] w_addr,
    input  logic [31:0]     w_data,
    output logic [AW_O-1:0] b_addr,
    input  logic [31:0]     b_data,
    output logic [31:0]     mul_x,
    output logic [31:0]     mul_y,
    input  logic [31:0]     mul_z,
    output logic [31:0]     add_a,
    output logic [31:0]     add_b,
    input  logic [31:0]     add_out,
    output logic            out_we,
    output logic [AW_O-1:0] out_addr,
    output logic [31:0]     out_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [AW_A-1:0] I_LAST = AW_A'(N_IN - 1);
    localparam logic [AW_O-1:0] J_LAST = AW_O'(N_OUT - 1);
    localparam logic [AW_W-1:0] W_STEP = AW_W'(N_IN);

    state_t          state;
    state_t          state_nx;
    logic [AW_O-1:0] j;
    logic [AW_A-1:0] i;
    // j*N_IN kept as a running sum so no multiplier is needed
    logic [AW_W-1:0] wbase;
    logic [31:0]     acc;

    // Last operands seen by the arithmetic units, held outside MAC
    logic [31:0]     mx_q;
    logic [31:0]     my_q;
    logic [31:0]     aa_q;
    logic [31:0]     ab_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            j     <= '0;
            i     <= '0;
            wbase <= '0;
            acc   <= '0;
            mx_q  <= '0;
            my_q  <= '0;
            aa_q  <= '0;
            ab_q  <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        j     <= '0;
                        wbase <= '0;
                    end
                end
                S_FETCH: begin
                    i <= '0;
                end
                S_MAC: begin
                    acc  <= add_out;
                    i    <= i + AW_A'(1);
                    mx_q <= act_data;
                    my_q <= w_data;
                    aa_q <= add_a;
                    ab_q <= add_b;
                end
                S_WRITE: begin
                    if (j != J_LAST) begin
                        j     <= j + AW_O'(1);
                        wbase <= wbase + W_STEP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        out_we   = 1'b0;
        out_addr = '0;
        out_data = '0;
        act_addr = '0;
        w_addr   = '0;
        b_addr   = '0;
        mul_x    = mx_q;
        mul_y    = my_q;
        add_a    = aa_q;
        add_b    = ab_q;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                busy     = 1'b1;
                b_addr   = j;
                act_addr = '0;
                w_addr   = wbase;
                state_nx = S_MAC;
            end
            S_MAC: begin
                busy     = 1'b1;
                // Prefetch index i+1 while index i is being accumulated
                act_addr = i + AW_A'(1);
                w_addr   = wbase + AW_W'(i) + AW_W'(1);
                mul_x    = act_data;
                mul_y    = w_data;
                // The bias seeds the sum in place of a separate init cycle
                add_a    = (i == '0) ? b_data : acc;
                add_b    = mul_z;
                if (i == I_LAST) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                busy     = 1'b1;
                out_we   = 1'b1;
                out_addr = j;
                // ReLU on the sign bit alone; -0.0 also becomes +0
                out_data = acc[31] ? 32'h0 : acc;
                state_nx = (j == J_LAST) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_node_layer_sequencer.sv
// Bench for node_layer_sequencer: behavioural memories and float units,
// reference sums computed per neuron and compared at every cycle.
module tb_node_layer_sequencer;

    localparam int N_IN  = 15;
    localparam int N_OUT = 32;
    localparam int AW_A  = 4;
    localparam int AW_W  = 9;
    localparam int AW_O  = 5;
    localparam int PER   = N_IN + 2;
    localparam int LAT   = N_OUT * PER + 1;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            busy;
    logic            done;
    logic [AW_A-1:0] act_addr;
    logic [31:0]     act_data;
    logic [AW_W-1:0] w_addr;
    logic [31:0]     w_data;
    logic [AW_O-1:0] b_addr;
    logic [31:0]     b_data;
    logic [31:0]     mul_x;
    logic [31:0]     mul_y;
    logic [31:0]     mul_z;
    logic [31:0]     add_a;
    logic [31:0]     add_b;
    logic [31:0]     add_out;
    logic            out_we;
    logic [AW_O-1:0] out_addr;
    logic [31:0]     out_data;

    logic [31:0] act_mem [16];
    logic [31:0] w_mem   [512];
    logic [31:0] b_mem   [32];

    int checks = 0;
    int errors = 0;

    node_layer_sequencer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .AW_A(AW_A), .AW_W(AW_W), .AW_O(AW_O)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .act_addr(act_addr), .act_data(act_data),
        .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data),
        .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
        .add_a(add_a), .add_b(add_b), .add_out(add_out),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single precision <-> real; exact for zeros and normal numbers
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) d = {b[31], 63'd0};
        else d = {b[31], {3'd0, b[30:23]} + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] i2sp(input int k);
        return r2sp($itor(k));
    endfunction

    assign mul_z   = r2sp(sp2r(mul_x) * sp2r(mul_y));
    assign add_out = r2sp(sp2r(add_a) + sp2r(add_b));

    always_ff @(posedge clk) begin
        act_data <= act_mem[act_addr];
        w_data   <= w_mem[w_addr];
        b_data   <= b_mem[b_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":busy"}, 32'(busy), 32'd0);
        chk({tag, ":done"}, 32'(done), 32'd0);
        chk({tag, ":out_we"}, 32'(out_we), 32'd0);
        chk({tag, ":act_addr"}, 32'(act_addr), 32'd0);
        chk({tag, ":w_addr"}, 32'(w_addr), 32'd0);
        chk({tag, ":b_addr"}, 32'(b_addr), 32'd0);
        chk({tag, ":out_addr"}, 32'(out_addr), 32'd0);
        chk({tag, ":out_data"}, out_data, 32'd0);
        chk({tag, ":mul_x"}, mul_x, 32'd0);
        chk({tag, ":mul_y"}, mul_y, 32'd0);
        chk({tag, ":add_a"}, add_a, 32'd0);
        chk({tag, ":add_b"}, add_b, 32'd0);
    endtask

    // mode 0 random small integers, 1 all-ones, 2 negative weights,
    // 3 forced -0.0, 4 bias passthrough
    task automatic fill(input int mode);
        for (int k = 0; k < 16; k++) begin
            unique case (mode)
                1, 2:    act_mem[k] = 32'h3F800000;
                3, 4:    act_mem[k] = 32'h0;
                default: act_mem[k] = i2sp(int'($urandom_range(16)) - 8);
            endcase
        end
        for (int k = 0; k < 512; k++) begin
            unique case (mode)
                1:       w_mem[k] = 32'h3F800000;
                2, 3:    w_mem[k] = 32'hBF800000;
                4:       w_mem[k] = i2sp(int'($urandom_range(6)) - 3);
                default: w_mem[k] = i2sp(int'($urandom_range(16)) - 8);
            endcase
        end
        for (int k = 0; k < 32; k++) begin
            unique case (mode)
                1, 2:    b_mem[k] = 32'h0;
                3:       b_mem[k] = 32'h80000000;
                4:       b_mem[k] = 32'h3DE65E81;
                default: b_mem[k] = i2sp(int'($urandom_range(40)) - 20);
            endcase
        end
    endtask

    // Starts a run in the current cycle; returns in the idle cycle after
    // done, or shortly after an abort by reset at cycle abort_at.
    task automatic run_layer(input string name, input bit mid_start,
                             input bit done_start, input int abort_at,
                             input logic [31:0] fixed_out, input bit use_fixed);
        real         part;
        int          nw;
        int          nd;
        logic [31:0] expv;
        part = 0.0;
        nw   = 0;
        nd   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= LAT + 1; c++) begin
            int j;
            int ph;
            j  = (c - 1) / PER;
            ph = (c - 1) % PER;
            if (abort_at > 0 && c == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero({name, ":abort"});
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk({name, ":rst_busy"}, 32'(busy), 32'd0);
                    chk({name, ":rst_we"}, 32'(out_we), 32'd0);
                end
                rst_n = 1'b1;
                for (int k = 0; k < 40; k++) begin
                    step();
                    chk({name, ":post_busy"}, 32'(busy), 32'd0);
                    chk({name, ":post_we"}, 32'(out_we), 32'd0);
                    chk({name, ":post_done"}, 32'(done), 32'd0);
                end
                return;
            end
            if (mid_start && c == 100) start = 1'b1;
            if (mid_start && c == 101) start = 1'b0;
            if (c < LAT) begin
                chk({name, ":busy"}, 32'(busy), 32'd1);
                chk({name, ":done_early"}, 32'(done), 32'd0);
                if (ph == 0) begin
                    chk({name, ":fetch_b_addr"}, 32'(b_addr), 32'(j));
                    chk({name, ":fetch_act_addr"}, 32'(act_addr), 32'd0);
                    chk({name, ":fetch_w_addr"}, 32'(w_addr), 32'(j * N_IN));
                    chk({name, ":we_idle"}, 32'(out_we), 32'd0);
                    part = sp2r(b_mem[j]);
                end else if (ph <= N_IN) begin
                    int i;
                    i = ph - 1;
                    chk({name, ":add_a"}, add_a, r2sp(part));
                    chk({name, ":we_mac"}, 32'(out_we), 32'd0);
                    if (i < N_IN - 1) begin
                        chk({name, ":mac_act_addr"}, 32'(act_addr), 32'(i + 1));
                        chk({name, ":mac_w_addr"}, 32'(w_addr),
                            32'(j * N_IN + i + 1));
                    end
                    part = part + sp2r(act_mem[i]) * sp2r(w_mem[j * N_IN + i]);
                end else begin
                    expv = (part > 0.0) ? r2sp(part) : 32'h0;
                    if (use_fixed) expv = fixed_out;
                    chk({name, ":out_we"}, 32'(out_we), 32'd1);
                    chk({name, ":out_addr"}, 32'(out_addr), 32'(j));
                    chk({name, ":out_data"}, out_data, expv);
                    if (out_we) nw++;
                end
            end else if (c == LAT) begin
                chk({name, ":done"}, 32'(done), 32'd1);
                chk({name, ":done_busy"}, 32'(busy), 32'd0);
                chk({name, ":done_we"}, 32'(out_we), 32'd0);
                if (done) nd++;
                if (done_start) start = 1'b1;
            end else begin
                start = 1'b0;
                chk({name, ":idle_busy"}, 32'(busy), 32'd0);
                chk({name, ":idle_done"}, 32'(done), 32'd0);
            end
            if (c < LAT + 1) step();
        end
        chk({name, ":writes"}, 32'(nw), 32'(N_OUT));
        chk({name, ":dones"}, 32'(nd), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fill(0);
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        fill(1);
        run_layer("ones", 1'b1, 1'b1, 0, 32'h41700000, 1'b1);
        fill(2);
        run_layer("neg", 1'b0, 1'b0, 0, 32'h0, 1'b1);
        fill(3);
        run_layer("negzero", 1'b0, 1'b0, 0, 32'h0, 1'b1);
        fill(4);
        run_layer("bias", 1'b0, 1'b0, 0, 32'h3DE65E81, 1'b1);
        fill(0);
        run_layer("abort", 1'b0, 1'b0, 300, 32'h0, 1'b0);
        fill(0);
        run_layer("rand1", 1'b0, 1'b0, 0, 32'h0, 1'b0);
        fill(0);
        run_layer("rand2", 1'b1, 1'b0, 0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
